// File: rtl/line_clear_ctrl.sv
// ---------------------------------------------------------------------------
// line_clear_ctrl
//
// Sequences a line-clear pass over the playfield rows after a piece has been
// written. Each loop broadcasts CHECK so the rows capture their full flags,
// evaluates those flags, and if any row is full, shifts everything at or above
// the bottom-most full row down by one. The loop repeats until no row is full,
// then reports how many rows were removed.
//
// Optional feature macro: LINE_CLEAR_SCORE_EN
//   defined   -> score accumulates 0/40/100/300/1200 points per pass for
//                0/1/2/3/>=4 lines, saturating at 16'hFFFF
//   undefined -> score is tied to zero and no adder exists
//
// Parameters
//   ROWS           number of playfield rows (0 = top, ROWS-1 = bottom)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          one-cycle request to run a pass (ignored while busy/FINISH)
//   full[ROWS]     per-row registered "row full" flags from the row registers
//   row_state[3]   broadcast row command: 000 check, 001 hold, 011 shift
//   shift_row[ROWS] per-row shift enable (row i loads row i-1)
//   busy           high while a pass is in progress (CHECK/EVAL/SHIFT)
//   done           one-cycle pulse when a pass completes
//   lines_cleared[3] rows removed by the last completed pass, saturates at 7
//   score[16]      accumulated score (zero unless LINE_CLEAR_SCORE_EN)
// ---------------------------------------------------------------------------
module line_clear_ctrl #(
  parameter int ROWS = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ROWS-1:0] full,
  output logic [2:0]      row_state,
  output logic [ROWS-1:0] shift_row,
  output logic            busy,
  output logic            done,
  output logic [2:0]      lines_cleared,
  output logic [15:0]     score
);

  localparam logic [2:0] RS_CHECK = 3'b000;
  localparam logic [2:0] RS_HOLD  = 3'b001;
  localparam logic [2:0] RS_SHIFT = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    EVAL,
    SHIFT,
    FINISH
  } state_t;

  state_t          state;
  logic [2:0]      pass_cnt;
  logic [ROWS-1:0] shift_mask;

  // Saturating increment of the 3-bit pass counter.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Every row at or above the bottom-most full row moves down one place, so
  // the mask is the full vector smeared from its highest set bit toward bit 0.
  always_comb begin
    logic acc;
    acc        = 1'b0;
    shift_mask = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      acc           = acc | full[i];
      shift_mask[i] = acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      row_state     <= RS_HOLD;
      shift_row     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= 3'd0;
      pass_cnt      <= 3'd0;
    end else begin
      // Pulses and shift enables last a single cycle unless re-asserted below.
      done      <= 1'b0;
      shift_row <= '0;
      case (state)
        IDLE: begin
          row_state <= RS_HOLD;
          if (start) begin
            state     <= CHECK;
            row_state <= RS_CHECK;
            busy      <= 1'b1;
            pass_cnt  <= 3'd0;
          end
        end
        CHECK: begin
          // Rows capture their full flags on this closing edge.
          state     <= EVAL;
          row_state <= RS_HOLD;
        end
        EVAL: begin
          if (full == '0) begin
            state         <= FINISH;
            row_state     <= RS_HOLD;
            busy          <= 1'b0;
            done          <= 1'b1;
            lines_cleared <= pass_cnt;
          end else begin
            state     <= SHIFT;
            row_state <= RS_SHIFT;
            shift_row <= shift_mask;
          end
        end
        SHIFT: begin
          // One row removed; re-check because rows above may also be full.
          state     <= CHECK;
          row_state <= RS_CHECK;
          pass_cnt  <= sat_inc3(pass_cnt);
        end
        FINISH: begin
          // A start arriving here is dropped; the next IDLE cycle accepts one.
          state     <= IDLE;
          row_state <= RS_HOLD;
        end
        default: begin
          state     <= IDLE;
          row_state <= RS_HOLD;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  // Points awarded for one completed pass.
  function automatic logic [15:0] pass_points(input logic [2:0] lines);
    case (lines)
      3'd0:    return 16'd0;
      3'd1:    return 16'd40;
      3'd2:    return 16'd100;
      3'd3:    return 16'd300;
      default: return 16'd1200;
    endcase
  endfunction

  // 16-bit unsigned add clamped at full scale.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Updated on the same edge that raises done, alongside lines_cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score <= 16'd0;
    end else if (state == EVAL && full == '0) begin
      score <= sat_add16(score, pass_points(pass_cnt));
    end
  end
`else
  assign score = 16'd0;
`endif

endmodule

// File: doc/line_clear_ctrl.md
LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 Parameter: ROWS, default 20, number of playfield rows; index 0 = top row, ROWS-1 = bottom row.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  one-cycle request to run a line-clear pass after a piece is written to the rows.
REQ-005 Port: full  input  ROWS  per-row registered "row full" flags returned by the row registers.
REQ-006 Port: row_state  output  3  state code broadcast to all rows: 000 check, 001 hold, 011 shift.
REQ-007 Port: shift_row  output  ROWS  per-row shift enable; a row with its bit high loads its upper neighbour's value during shift.
REQ-008 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-009 Port: done  output  1  one-cycle pulse when a pass completes.
REQ-010 Port: lines_cleared  output  3  rows removed in the last completed pass; saturates at 7.
REQ-011 Port: score  output  16  accumulated score; see Configuration.

Function
REQ-012 FSM states: IDLE, CHECK, EVAL, SHIFT, FINISH; all registered, no combinational outputs from inputs except where stated.
REQ-013 IDLE: row_state=001, shift_row=0, busy=0; start=1 -> CHECK next cycle, pass counter cleared.
REQ-014 CHECK: row_state=000 for exactly one cycle; rows capture full flags at the closing edge -> EVAL.
REQ-015 EVAL: row_state=001; sample full; full==0 -> FINISH; otherwise select k = highest index with full[k]=1 -> SHIFT.
REQ-016 SHIFT: row_state=011 for exactly one cycle; shift_row[i]=1 for all i<=k, 0 for i>k; pass counter +1 (saturating at 7) -> CHECK.
REQ-017 Exactly one row removed per SHIFT; multiple full rows are removed by repeated CHECK/EVAL/SHIFT loops, bottom-most first.
REQ-018 FINISH: done=1 for one cycle, lines_cleared <= pass counter, score updated, busy=0 -> IDLE.
REQ-019 Latency: pass with zero full rows: done 3 cycles after start sampled; each cleared row adds 3 cycles.
REQ-020 start while busy=1 is ignored, not queued.
REQ-021 start in the FINISH cycle is ignored; start in the following IDLE cycle is accepted.
REQ-022 shift_row is all-zero in every state other than SHIFT.
REQ-023 Bit of full for row 0 set while every other bit is clear -> k=0, only shift_row[0]=1.
REQ-024 lines_cleared holds its value between passes; updates only in FINISH.

Reset
REQ-025 reset=1 forces IDLE immediately, regardless of clock, including mid-pass.
REQ-026 Reset values: row_state=001, shift_row=0, busy=0, done=0, lines_cleared=0, score=0, pass counter=0.
REQ-027 First start is accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro LINE_CLEAR_SCORE_EN defined: in FINISH, score += 0/40/100/300/1200 for lines_cleared 0/1/2/3/>=4, saturating at 16'hFFFF.
REQ-029 Macro LINE_CLEAR_SCORE_EN undefined: score tied to 0; no score adder is synthesised; all other behaviour identical.

Verification
REQ-030 ROWS=20, start with full=0 -> row_state 000 then 001, done 3 cycles after start, lines_cleared=0, score unchanged.
REQ-031 full[19]=1 only (deasserted after the shift) -> one SHIFT with shift_row=20'hFFFFF, done at cycle 6, lines_cleared=1, score=40 (SCORE_EN).
REQ-032 full[16..19] cleared one per loop -> four SHIFT cycles, each with shift_row=20'hFFFFF, lines_cleared=4, score += 1200.
REQ-033 full[5]=1 only -> shift_row=20'h0003F in the single SHIFT cycle.
REQ-034 reset asserted during SHIFT -> same-cycle outputs at reset values, busy=0, next start runs a clean pass.
REQ-035 start pulsed during EVAL of an active pass -> ignored, exactly one done pulse, score at 16'hFFF0 plus 1200 saturates to 16'hFFFF.
